udp_order_parser: RTL

//  Front stage of trading_system_top on the clk_udp domain. Consumes the raw Ethernet/IPv4/UDP

---
 rtl/hft_pkg.sv | 39 +++
 rtl/order_word_fifo.sv | 51 +++++
 rtl/udp_order_parser.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hft_pkg.sv
// Shared constants and types for the UDP order front end: order word layout,
// opcode values, header byte offsets and the parser state encoding.
package hft_pkg;

    // Order word layout: {price[31:16], is_buy[15], is_bot[14], qty[13:0]}
    localparam int PRICE_MSB = 31;
    localparam int PRICE_LSB = 16;
    localparam int BUY_BIT   = 15;
    localparam int BOT_BIT   = 14;
    localparam int QTY_W     = 14;

    // Opcodes carried in frame bytes 42-44
    localparam logic [23:0] OPC_MARKET = 24'h102030;
    localparam logic [23:0] OPC_DUMP   = 24'hF0E0D0;

    // Fixed header values that are checked
    localparam logic [7:0] ETH_TYPE_HI  = 8'h08;
    localparam logic [7:0] ETH_TYPE_LO  = 8'h00;
    localparam logic [7:0] IP_PROTO_UDP = 8'h11;

    // Byte offsets inside the Ethernet/IPv4/UDP frame
    localparam logic [5:0] ETH_TYPE_OFS = 6'd12;
    localparam logic [5:0] IP_PROTO_OFS = 6'd23;
    localparam logic [5:0] DIP_OFS      = 6'd30;
    localparam logic [5:0] SPORT_OFS    = 6'd34;
    localparam logic [5:0] OPC_OFS      = 6'd42;
    localparam logic [5:0] PAYLOAD_OFS  = 6'd45;

    // S_SKIP discards the tail of a dump frame without counting a drop
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_OPC,
        S_PAYLOAD,
        S_DROP,
        S_SKIP
    } parser_state_t;

endpackage

// File: rtl/order_word_fifo.sv
// Small synchronous FIFO holding assembled order words. The head entry is
// presented combinationally (show-ahead) and forced to zero while empty.
module order_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
)(
    input  logic             clk_udp,
    input  logic             rst_udp_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    // Pointer advance on accepted push/pop
    always_ff @(posedge clk_udp or negedge rst_udp_n) begin
        if (!rst_udp_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks the head
    always_ff @(posedge clk_udp) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/udp_order_parser.sv
// UDP order parser: filters Ethernet/IPv4/UDP frames byte by byte, decodes
// the opcode, packs payload bytes into 32-bit order words (MSB first) and
// queues them, or pulses dump_req for a dump request.
module udp_order_parser
    import hft_pkg::*;
#(
    parameter logic [31:0] DEST_IP    = 32'hC0A80132,
    parameter logic [15:0] SRC_PORT   = 16'd55555,
    parameter logic [23:0] OP_MARKET  = OPC_MARKET,
    parameter logic [23:0] OP_DUMP    = OPC_DUMP,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 16
)(
    input  logic             clk_udp,
    input  logic             rst_udp_n,
    input  logic [7:0]       rx_axis_tdata,
    input  logic             rx_axis_tvalid,
    input  logic             rx_axis_tlast,
    output logic [31:0]      order_tdata,
    output logic             order_tvalid,
    input  logic             order_tready,
    output logic             dump_req,
    output logic [CNT_W-1:0] frame_drop_cnt,
    output logic [CNT_W-1:0] order_ovf_cnt,
    output logic             parser_busy
);

    localparam logic [5:0] HDR_LAST = OPC_OFS - 6'd1;
    localparam logic [5:0] OPC_LAST = OPC_OFS + 6'd2;

    parser_state_t    state_reg, state_next;
    logic [5:0]       idx_reg;
    logic [15:0]      opc_reg;
    logic [1:0]       lane_reg;
    logic [23:0]      shift_reg;
    logic             dump_req_reg;
    logic [CNT_W-1:0] drop_cnt_reg;
    logic [CNT_W-1:0] ovf_cnt_reg;

    logic [23:0]      opc_word;
    logic [7:0]       exp_byte;
    logic             exp_en;
    logic             hdr_bad;
    logic             drop_evt;
    logic             dump_evt;
    logic             push_evt;
    logic [31:0]      push_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ovf_evt;

    // Opcode as it stands once the third opcode byte is on the bus
    assign opc_word  = {opc_reg, rx_axis_tdata};
    assign push_word = {shift_reg, rx_axis_tdata};

    // Expected value for the header byte at the current index (don't-care elsewhere)
    always_comb begin
        exp_en   = 1'b1;
        exp_byte = 8'h00;
        case (idx_reg)
            ETH_TYPE_OFS:        exp_byte = ETH_TYPE_HI;
            ETH_TYPE_OFS + 6'd1: exp_byte = ETH_TYPE_LO;
            IP_PROTO_OFS:        exp_byte = IP_PROTO_UDP;
            DIP_OFS:             exp_byte = DEST_IP[31:24];
            DIP_OFS + 6'd1:      exp_byte = DEST_IP[23:16];
            DIP_OFS + 6'd2:      exp_byte = DEST_IP[15:8];
            DIP_OFS + 6'd3:      exp_byte = DEST_IP[7:0];
            SPORT_OFS:           exp_byte = SRC_PORT[15:8];
            SPORT_OFS + 6'd1:    exp_byte = SRC_PORT[7:0];
            default:             exp_en   = 1'b0;
        endcase
    end

    assign hdr_bad = exp_en && (rx_axis_tdata != exp_byte);

    // State register
    always_ff @(posedge clk_udp or negedge rst_udp_n) begin
        if (!rst_udp_n) state_reg <= S_IDLE;
        else            state_reg <= state_next;
    end

    // Next-state decision; tlast always returns to idle so frames can abut
    always_comb begin
        state_next = state_reg;
        if (rx_axis_tvalid) begin
            case (state_reg)
                S_IDLE, S_HDR: begin
                    if (rx_axis_tlast)             state_next = S_IDLE;
                    else if (hdr_bad)              state_next = S_DROP;
                    else if (idx_reg == HDR_LAST)  state_next = S_OPC;
                    else                           state_next = S_HDR;
                end
                S_OPC: begin
                    if (rx_axis_tlast)                 state_next = S_IDLE;
                    else if (idx_reg == OPC_LAST) begin
                        if (opc_word == OP_MARKET)     state_next = S_PAYLOAD;
                        else if (opc_word == OP_DUMP)  state_next = S_SKIP;
                        else                           state_next = S_DROP;
                    end
                end
                default: begin
                    if (rx_axis_tlast) state_next = S_IDLE;
                end
            endcase
        end
    end

    // Per-beat events: drop counted once at the rejecting beat, dump at opcode end
    always_comb begin
        drop_evt = 1'b0;
        dump_evt = 1'b0;
        push_evt = 1'b0;
        if (rx_axis_tvalid) begin
            case (state_reg)
                S_IDLE, S_HDR: drop_evt = hdr_bad || rx_axis_tlast;
                S_OPC: begin
                    if (idx_reg == OPC_LAST) begin
                        dump_evt = (opc_word == OP_DUMP);
                        drop_evt = (opc_word != OP_MARKET) && (opc_word != OP_DUMP);
                    end else begin
                        drop_evt = rx_axis_tlast;
                    end
                end
                S_PAYLOAD: push_evt = (lane_reg == 2'd3);
                default: ;
            endcase
        end
    end

    // Byte index, opcode capture, payload lane/shift register and dump pulse
    always_ff @(posedge clk_udp or negedge rst_udp_n) begin
        if (!rst_udp_n) begin
            idx_reg      <= '0;
            opc_reg      <= '0;
            lane_reg     <= '0;
            shift_reg    <= '0;
            dump_req_reg <= 1'b0;
        end else begin
            dump_req_reg <= dump_evt;
            if (rx_axis_tvalid) begin
                if (rx_axis_tlast)                 idx_reg <= '0;
                else if (idx_reg != PAYLOAD_OFS)   idx_reg <= idx_reg + 6'd1;
                if (state_reg == S_OPC)            opc_reg <= {opc_reg[7:0], rx_axis_tdata};
                if (state_reg == S_PAYLOAD) begin
                    shift_reg <= {shift_reg[15:0], rx_axis_tdata};
                    lane_reg  <= rx_axis_tlast ? 2'd0 : lane_reg + 2'd1;
                end else begin
                    lane_reg  <= 2'd0;
                end
            end
        end
    end

    // A push is lost only when the FIFO is full and the head is not leaving
    assign ovf_evt = push_evt && fifo_full && !order_tready;

    // Saturating statistics
    always_ff @(posedge clk_udp or negedge rst_udp_n) begin
        if (!rst_udp_n) begin
            drop_cnt_reg <= '0;
            ovf_cnt_reg  <= '0;
        end else begin
            if (drop_evt && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + 1'b1;
            if (ovf_evt  && (ovf_cnt_reg  != '1)) ovf_cnt_reg  <= ovf_cnt_reg + 1'b1;
        end
    end

    order_word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_udp   (clk_udp),
        .rst_udp_n (rst_udp_n),
        .push      (push_evt),
        .push_data (push_word),
        .pop       (order_tready),
        .head_data (order_tdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign order_tvalid   = !fifo_empty;
    assign dump_req       = dump_req_reg;
    assign frame_drop_cnt = drop_cnt_reg;
    assign order_ovf_cnt  = ovf_cnt_reg;
    assign parser_busy    = (state_reg != S_IDLE) || !fifo_empty;

endmodule
